// File: rtl/booth_seq_multiplier.sv
// rtl/booth_seq_multiplier.sv - sequential radix-2 Booth multiplier with valid/ready handshakes
//
// Purpose:
//   Multiplies two signed WIDTH-bit operands into a signed 2*WIDTH-bit product.
//   One multiplier bit pair is scanned per cycle.
//   Each Booth digit {-M, 0, +M} is shifted and added into an accumulator.
//
// Optional feature macro: BOOTH_EARLY_TERM_EN
//   When defined, RUN ends as soon as every remaining Booth digit is zero.
//   When undefined, RUN always lasts WIDTH cycles.
//
// Ports:
//   clk           in   1          single clock, rising edge
//   rst           in   1          synchronous, active-high reset
//   in_valid      in   1          operands valid
//   in_ready      out  1          block can accept operands (IDLE and not in reset)
//   multiplicand  in   WIDTH      signed M
//   multiplier    in   WIDTH      signed Q
//   out_valid     out  1          product valid (DONE)
//   out_ready     in   1          downstream accepts product
//   product       out  2*WIDTH    signed M*Q, held until the next RUN->DONE edge
//   busy          out  1          high in RUN

module booth_seq_multiplier #(
    parameter int WIDTH = 26
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [PW-1:0]   m_reg;
    logic [WIDTH-1:0] q_reg;
    logic            prev;
    logic [PW-1:0]   acc;
    logic [CW-1:0]   cnt;

    logic            q_bit;
    logic [PW-1:0]   m_shift;
    logic [PW-1:0]   acc_next;
    logic            last_iter;
    logic            finish;
    logic            accept;

    // Booth digit evaluation for the current bit pair {Q[cnt], prev}
    always_comb begin
        q_bit   = q_reg[cnt];
        m_shift = m_reg << cnt;
        case ({q_bit, prev})
            2'b01:   acc_next = acc + m_shift;
            2'b10:   acc_next = acc - m_shift;
            default: acc_next = acc;
        endcase
    end

    assign last_iter = (cnt == LAST_CNT);

`ifdef BOOTH_EARLY_TERM_EN
    // After shifting, bit 0 of rest is Q[cnt]^Q[cnt] = 0.
    // So the upper bits Q[WIDTH-1:cnt+1] all equal Q[cnt] exactly when rest[WIDTH-1:1] is zero.
    // In that case every remaining digit pair is 00 or 11 and contributes nothing.
    logic [WIDTH-1:0] rest;
    always_comb begin
        rest   = (q_reg ^ {WIDTH{q_bit}}) >> cnt;
        finish = last_iter | (rest[WIDTH-1:1] == '0);
    end
`else
    assign finish = last_iter;
`endif

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid && !rst) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (finish) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = in_valid & in_ready;

    // State register and datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            m_reg   <= '0;
            q_reg   <= '0;
            prev    <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                m_reg <= {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand};
                q_reg <= multiplier;
                prev  <= 1'b0;
                acc   <= '0;
                cnt   <= '0;
            end else if (state == RUN) begin
                acc  <= acc_next;
                prev <= q_bit;
                // cnt stops at the terminal value; it is reloaded on the next accept
                if (!last_iter) begin
                    cnt <= cnt + CW'(1);
                end
                if (finish) begin
                    product <= acc_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// tb/tb_booth_seq_multiplier.sv - scoreboard testbench for booth_seq_multiplier

module tb_booth_seq_multiplier;

    localparam int W  = 26;
    localparam int PW = 2 * W;

`ifdef BOOTH_EARLY_TERM_EN
    localparam int LAT_Q0   = 1;
    localparam int LAT_Q1   = 2;
    localparam int LAT_QM1  = 1;
`else
    localparam int LAT_Q0   = W;
    localparam int LAT_Q1   = W;
    localparam int LAT_QM1  = W;
`endif

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  multiplicand;
    logic [W-1:0]  multiplier;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] product;
    logic          busy;

    logic          rand_ready;
    logic          force_ready;

    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] got_q[$];
    int            sent;
    int            recvd;
    int            errors;
    int            checks;

    booth_seq_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sole driver of out_ready: fixed level or random stalls
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;
        end
    end

    // Output monitor: records every completed handshake
    initial recvd = 0;
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            got_q.push_back(product);
            recvd++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] model(input logic [W-1:0] m, input logic [W-1:0] q);
        longint a;
        longint b;
        longint p;
        a = longint'($signed(m));
        b = longint'($signed(q));
        p = a * b;
        return p[PW-1:0];
    endfunction

    function automatic int exp_lat(input logic [W-1:0] q);
`ifdef BOOTH_EARLY_TERM_EN
        for (int i = 0; i < W; i++) begin
            bit same;
            same = 1'b1;
            for (int j = i + 1; j < W; j++) begin
                if (q[j] != q[i]) same = 1'b0;
            end
            if (same) return i + 1;
        end
        return W;
`else
        return (q === 'x) ? 0 : W;
`endif
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 9))
            0:       return '0;
            1:       return '1;
            2:       return 26'h2000000;
            3:       return 26'h1FFFFFF;
            4:       return 26'd1;
            default: return 26'($urandom());
        endcase
    endfunction

    task automatic accept(input logic [W-1:0] m, input logic [W-1:0] q, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", n < 400, 1);
        in_valid     = 1'b1;
        multiplicand = m;
        multiplier   = q;
        if (push) begin
            exp_q.push_back(model(m, q));
            sent++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic drain();
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            check("product", got_q.pop_front(), exp_q.pop_front());
        end
        check("leftover_got", got_q.size(), 0);
        check("leftover_exp", exp_q.size(), 0);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] m, input logic [W-1:0] q,
                          input logic [PW-1:0] exp_p, input int lat_exp);
        int lat;
        accept(m, q, 1'b1);
        wait_done(lat);
        check({tag, "_lat"}, lat, lat_exp);
        check({tag, "_product"}, product, exp_p);
        repeat (2) @(posedge clk);
        #1;
        drain();
    endtask

    initial begin
        int lat;
        logic [W-1:0]  m3;
        logic [W-1:0]  q3;
        logic [PW-1:0] p3;

        errors       = 0;
        checks       = 0;
        sent         = 0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        rand_ready   = 1'b0;
        force_ready  = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1);
        check("idle_product", product, 0);

        // Basic and extreme operands
        run_op("t1", 26'd3, 26'h3FFFFFB, 52'hFFFFFFFFFFFF1, exp_lat(26'h3FFFFFB));
        run_op("t2a", 26'h2000000, 26'h2000000, 52'h4000000000000, W);
        run_op("t2b", 26'h1FFFFFF, 26'h2000000, 52'hC000002000000, W);

        // Backpressure in DONE with ignored new operands
        force_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m3 = 26'(-123);
        q3 = 26'd456;
        p3 = model(m3, q3);
        accept(m3, q3, 1'b1);
        wait_done(lat);
        check("t3_lat", lat, exp_lat(q3));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid     = (i == 3);
            multiplicand = 26'h155AA33;
            multiplier   = 26'h0F0F0F1;
            @(posedge clk);
            #1;
            check("t3_hold_product", product, p3);
            check("t3_hold_in_ready", in_ready, 0);
            check("t3_hold_out_valid", out_valid, 1);
        end
        in_valid    = 1'b0;
        force_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        drain();
        run_op("t3_next", 26'd1234, 26'(-77), model(26'd1234, 26'(-77)), exp_lat(26'(-77)));

        // Reset mid-RUN aborts the operation
        accept(26'h0ABCDEF, 26'h2345678, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("t4_out_valid", out_valid, 0);
        check("t4_busy", busy, 0);
        check("t4_product", product, 0);
        check("t4_in_ready", in_ready, 1);
        run_op("t4_after", 26'd7, 26'd6, 52'd42, exp_lat(26'd6));

        // Early-termination corner operands
        run_op("t5_q0", 26'd5, 26'd0, 52'd0, LAT_Q0);
        run_op("t5_q1", 26'd9, 26'd1, 52'd9, LAT_Q1);
        run_op("t5_qm1", 26'd9, 26'h3FFFFFF, 52'hFFFFFFFFFFFF7, LAT_QM1);

        // Random operands with random output stalls
        rand_ready = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            accept(rnd_op(), rnd_op(), 1'b1);
            if (got_q.size() > 8) begin
                while (got_q.size() > 0 && exp_q.size() > 0) begin
                    check("rand_product", got_q.pop_front(), exp_q.pop_front());
                end
            end
        end
        begin
            int n;
            n = 0;
            while (recvd < sent && n < 1000) begin
                @(posedge clk);
                n++;
            end
            check("rand_drain_timeout", n < 1000, 1);
        end
        rand_ready  = 1'b0;
        force_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        drain();
        check("result_count", recvd, sent);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
